// File: rtl/div32_seq.sv
// Sequential restoring divider controller driving an external 32-bit add/sub unit.
// Optional signed support is enabled with `define DIV32_SIGNED_EN (adds signed_op port and FIX state).
module div32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co
);

`ifdef DIV32_SIGNED_EN
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] r, q, d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shifted, r_next, q_next;
  logic             take;
  logic             last_iter;
  logic             sign_fix;

`ifdef DIV32_SIGNED_EN
  logic sgn, neg_q, neg_r;
  assign sign_fix = sgn;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? ('0 - v) : v;
  endfunction
`else
  assign sign_fix = 1'b0;
`endif

  // A set top bit of R means the shifted partial remainder is >= 2^W > D,
  // so the subtraction is always taken and the W-bit difference is exact.
  assign shifted   = {r[WIDTH-2:0], q[WIDTH-1]};
  assign take      = r[WIDTH-1] | ~add_co;
  assign r_next    = take ? add_s : shifted;
  assign q_next    = {q[WIDTH-2:0], take};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (state)
      CALC: begin
        add_a   = shifted;
        add_b   = d;
        add_sub = 1'b1;
      end
`ifdef DIV32_SIGNED_EN
      FIX: begin
        add_b   = cnt[0] ? r : q;
        add_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
`ifdef DIV32_SIGNED_EN
      sgn       <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              done      <= 1'b1;
              div_zero  <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              r     <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CALC;
`ifdef DIV32_SIGNED_EN
              q     <= mag(dividend, signed_op);
              d     <= mag(divisor, signed_op);
              sgn   <= signed_op;
              neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r <= signed_op & dividend[WIDTH-1];
`else
              q     <= dividend;
              d     <= divisor;
`endif
            end
          end
        end
        CALC: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            if (sign_fix) begin
`ifdef DIV32_SIGNED_EN
              cnt   <= '0;
              state <= FIX;
`endif
            end else begin
              quotient  <= q_next;
              remainder <= r_next;
              done      <= 1'b1;
              div_zero  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
`ifdef DIV32_SIGNED_EN
        // Quotient is fixed into Q first so both results publish together with done.
        FIX: begin
          if (!cnt[0]) begin
            q   <= neg_q ? add_s : q;
            cnt <= cnt + CNT_W'(1);
          end else begin
            quotient  <= q;
            remainder <= neg_r ? add_s : r;
            done      <= 1'b1;
            div_zero  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
